// File: rtl/timer_pkg.sv
// Shared constants for the BCD stopwatch: per-digit limits, the digit
// index encoding used by the display scan, and the active-low anode
// patterns that go with each index.
package timer_pkg;

  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_ONES_MAX = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    IDX_S1  = 2'd0,
    IDX_S10 = 2'd1,
    IDX_M1  = 2'd2,
    IDX_M10 = 2'd3
  } digit_idx_e;

  localparam logic [3:0] SEL_S1  = 4'b1110;
  localparam logic [3:0] SEL_S10 = 4'b1101;
  localparam logic [3:0] SEL_M1  = 4'b1011;
  localparam logic [3:0] SEL_M10 = 4'b0111;

  // Anode pattern for a digit position; exactly one bit is low.
  function automatic logic [3:0] sel_pattern(input digit_idx_e idx);
    logic [3:0] sel;
    case (idx)
      IDX_S1:  sel = SEL_S1;
      IDX_S10: sel = SEL_S10;
      IDX_M1:  sel = SEL_M1;
      default: sel = SEL_M10;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/bcd_timer_if.sv
// Button inputs and display/status outputs of the stopwatch. The timer
// uses the slave view; whatever drives the buttons uses the master view.
interface bcd_timer_if;

  logic        start_stop;
  logic        clear;
  logic [15:0] digits;
  logic        running;
  logic        wrap;
  logic [3:0]  scan_digit;
  logic [3:0]  scan_sel;
  logic        dp;

  modport master (
    output start_stop, clear,
    input  digits, running, wrap, scan_digit, scan_sel, dp
  );

  modport slave (
    input  start_stop, clear,
    output digits, running, wrap, scan_digit, scan_sel, dp
  );

endinterface

// File: rtl/timer_digit.sv
// One BCD digit of the time cascade. Counts 0..MAX on inc, clears on clr
// (clr has priority), and raises carry when an increment rolls it over.
module timer_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] val_q;
  logic [3:0] val_d;

  // Next digit value: clear first, then increment with rollover at MAX.
  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = 4'd0;
    end else if (inc) begin
      val_d = (val_q == MAX) ? 4'd0 : val_q + 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= 4'd0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q     = val_q;
  assign carry = inc & (val_q == MAX);

endmodule

// File: rtl/bcd_timer.sv
// MM:SS stopwatch. A prescaler turns clk into one-second ticks while
// running, four chained BCD digits count the time, and a free-running
// scan counter multiplexes the digits onto one 4-bit bus for a shared
// 7-segment decoder driving a common-anode display.
module bcd_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic         clk,
  input  logic         rst,
  bcd_timer_if.slave   bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(SCAN_DIV - 1);

  logic          ss_prev_q,  ss_prev_d;
  logic          clr_prev_q, clr_prev_d;
  logic          running_q,  running_d;
  logic          wrap_q,     wrap_d;
  logic [PW-1:0] pcnt_q,     pcnt_d;
  logic [SW-1:0] scnt_q,     scnt_d;
  digit_idx_e    idx_q,      idx_d;

  logic ss_edge;
  logic clr_edge;
  logic tick;

  logic [3:0] s1, s10, m1, m10;
  logic       c_s1, c_s10, c_m1, c_m10;

  // Button edges, run toggle, prescaler and rollover pulse.
  always_comb begin
    ss_edge    = bus.start_stop & ~ss_prev_q;
    clr_edge   = bus.clear & ~clr_prev_q;
    tick       = running_q && (pcnt_q == PCNT_LAST);
    ss_prev_d  = bus.start_stop;
    clr_prev_d = bus.clear;
    running_d  = ss_edge ? ~running_q : running_q;
    pcnt_d     = pcnt_q;
    if (clr_edge) begin
      pcnt_d = '0;
    end else if (running_q) begin
      pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    end
    wrap_d = c_m10 & ~clr_edge;
  end

  // Scan counter and digit index; free-running so the display never stalls.
  always_comb begin
    scnt_d = scnt_q + SW'(1);
    idx_d  = idx_q;
    if (scnt_q == SCNT_LAST) begin
      scnt_d = '0;
      idx_d  = digit_idx_e'(idx_q + 2'd1);
    end
  end

  // Control and scan state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_prev_q  <= 1'b0;
      clr_prev_q <= 1'b0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
      pcnt_q     <= '0;
      scnt_q     <= '0;
      idx_q      <= IDX_S1;
    end else begin
      ss_prev_q  <= ss_prev_d;
      clr_prev_q <= clr_prev_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
      pcnt_q     <= pcnt_d;
      scnt_q     <= scnt_d;
      idx_q      <= idx_d;
    end
  end

  timer_digit #(.MAX(SEC_ONES_MAX)) u_s1 (
    .clk(clk), .rst(rst), .inc(tick),  .clr(clr_edge), .q(s1),  .carry(c_s1)
  );
  timer_digit #(.MAX(SEC_TENS_MAX)) u_s10 (
    .clk(clk), .rst(rst), .inc(c_s1),  .clr(clr_edge), .q(s10), .carry(c_s10)
  );
  timer_digit #(.MAX(MIN_ONES_MAX)) u_m1 (
    .clk(clk), .rst(rst), .inc(c_s10), .clr(clr_edge), .q(m1),  .carry(c_m1)
  );
  timer_digit #(.MAX(MIN_TENS_MAX)) u_m10 (
    .clk(clk), .rst(rst), .inc(c_m1),  .clr(clr_edge), .q(m10), .carry(c_m10)
  );

  // Scan bus: pick the selected digit; the colon sits after the minutes.
  always_comb begin
    case (idx_q)
      IDX_S1:  bus.scan_digit = s1;
      IDX_S10: bus.scan_digit = s10;
      IDX_M1:  bus.scan_digit = m1;
      default: bus.scan_digit = m10;
    endcase
    bus.scan_sel = sel_pattern(idx_q);
    bus.dp       = (idx_q != IDX_M1);
  end

  assign bus.digits  = {m10, m1, s10, s1};
  assign bus.running = running_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_timer.sv
// Directed bench for the stopwatch with TICK_DIV=4 and SCAN_DIV=2.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_bcd_timer;
  import timer_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  int   edge_cnt;

  logic [3:0] exp_dig [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
  logic [3:0] exp_sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  bcd_timer_if tif ();

  bcd_timer #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges seen since reset released; drives the expected scan position.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    tif.start_stop = 1'b1;
    step(1);
    tif.start_stop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tif.start_stop = 1'b0;
    tif.clear = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tif.start_stop = 1'b0;
    tif.clear = 1'b0;
    step(2);
    n_vec++; if (tif.digits !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset_digits: got %h want 0000", tif.digits); end
    n_vec++; if (tif.running !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_running: got %b want 0", tif.running); end
    n_vec++; if (tif.scan_sel !== 4'b1110) begin n_bad++; $display("[TB] FAIL reset_sel: got %b want 1110", tif.scan_sel); end
    n_vec++; if (tif.dp !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_dp: got %b want 1", tif.dp); end
    n_vec++; if (tif.wrap !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_wrap: got %b want 0", tif.wrap); end
    n_vec++; if (tif.scan_digit !== 4'h0) begin n_bad++; $display("[TB] FAIL reset_scan_digit: got %h want 0", tif.scan_digit); end
    rst = 1'b0;
  endtask

  task automatic test_run_stop();
    do_reset();
    press();
    n_vec++; if (tif.running !== 1'b1) begin n_bad++; $display("[TB] FAIL run_started: got %b want 1", tif.running); end
    step(3);
    n_vec++; if (tif.digits !== 16'h0000) begin n_bad++; $display("[TB] FAIL run_before_tick: got %h want 0000", tif.digits); end
    step(1);
    n_vec++; if (tif.digits !== 16'h0001) begin n_bad++; $display("[TB] FAIL run_first_tick: got %h want 0001", tif.digits); end
    step(36);
    n_vec++; if (tif.digits !== 16'h0010) begin n_bad++; $display("[TB] FAIL run_40_cycles: got %h want 0010", tif.digits); end
    tif.start_stop = 1'b1;
    step(1);
    n_vec++; if (tif.running !== 1'b0) begin n_bad++; $display("[TB] FAIL stop_running: got %b want 0", tif.running); end
    step(100);
    n_vec++; if (tif.running !== 1'b0) begin n_bad++; $display("[TB] FAIL held_button_once: got %b want 0", tif.running); end
    n_vec++; if (tif.digits !== 16'h0010) begin n_bad++; $display("[TB] FAIL stop_frozen: got %h want 0010", tif.digits); end
    tif.start_stop = 1'b0;
    step(1);
  endtask

  task automatic test_pause_resume();
    do_reset();
    press();
    step(1);
    press();
    n_vec++; if (tif.running !== 1'b0) begin n_bad++; $display("[TB] FAIL pause_running: got %b want 0", tif.running); end
    step(10);
    n_vec++; if (tif.digits !== 16'h0000) begin n_bad++; $display("[TB] FAIL pause_digits: got %h want 0000", tif.digits); end
    press();
    n_vec++; if (tif.running !== 1'b1) begin n_bad++; $display("[TB] FAIL resume_running: got %b want 1", tif.running); end
    step(1);
    n_vec++; if (tif.digits !== 16'h0000) begin n_bad++; $display("[TB] FAIL resume_one_cycle: got %h want 0000", tif.digits); end
    step(1);
    n_vec++; if (tif.digits !== 16'h0001) begin n_bad++; $display("[TB] FAIL resume_tick: got %h want 0001", tif.digits); end
  endtask

  task automatic test_rollover();
    logic [15:0] exp_d;
    int          mm;
    int          ss;
    do_reset();
    press();
    for (int k = 1; k <= 3600; k++) begin
      step(4);
      mm = (k / 60) % 60;
      ss = k % 60;
      exp_d = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
      n_vec++; if (tif.digits !== exp_d) begin n_bad++; $display("[TB] FAIL rollover_digits t=%0d: got %h want %h", k, tif.digits, exp_d); end
      n_vec++; if (tif.wrap !== (k == 3600)) begin n_bad++; $display("[TB] FAIL rollover_wrap t=%0d: got %b want %b", k, tif.wrap, (k == 3600)); end
    end
    step(1);
    n_vec++; if (tif.wrap !== 1'b0) begin n_bad++; $display("[TB] FAIL wrap_one_cycle: got %b want 0", tif.wrap); end
    n_vec++; if (tif.digits !== 16'h0000) begin n_bad++; $display("[TB] FAIL after_wrap: got %h want 0000", tif.digits); end
  endtask

  task automatic test_clear_tick();
    do_reset();
    press();
    step(28);
    n_vec++; if (tif.digits !== 16'h0007) begin n_bad++; $display("[TB] FAIL clear_pre: got %h want 0007", tif.digits); end
    step(3);
    tif.clear = 1'b1;
    step(1);
    tif.clear = 1'b0;
    n_vec++; if (tif.digits !== 16'h0000) begin n_bad++; $display("[TB] FAIL clear_wins: got %h want 0000", tif.digits); end
    n_vec++; if (tif.running !== 1'b1) begin n_bad++; $display("[TB] FAIL clear_keeps_run: got %b want 1", tif.running); end
    n_vec++; if (tif.wrap !== 1'b0) begin n_bad++; $display("[TB] FAIL clear_no_wrap: got %b want 0", tif.wrap); end
    step(3);
    n_vec++; if (tif.digits !== 16'h0000) begin n_bad++; $display("[TB] FAIL clear_hold: got %h want 0000", tif.digits); end
    step(1);
    n_vec++; if (tif.digits !== 16'h0001) begin n_bad++; $display("[TB] FAIL clear_next_tick: got %h want 0001", tif.digits); end
    tif.clear = 1'b1;
    tif.start_stop = 1'b1;
    step(1);
    tif.clear = 1'b0;
    tif.start_stop = 1'b0;
    n_vec++; if (tif.digits !== 16'h0000) begin n_bad++; $display("[TB] FAIL both_clear: got %h want 0000", tif.digits); end
    n_vec++; if (tif.running !== 1'b0) begin n_bad++; $display("[TB] FAIL both_toggle: got %b want 0", tif.running); end
  endtask

  task automatic test_scan();
    int ix;
    do_reset();
    press();
    step(754 * 4);
    press();
    n_vec++; if (tif.digits !== 16'h1234) begin n_bad++; $display("[TB] FAIL scan_setup: got %h want 1234", tif.digits); end
    for (int i = 0; i < 8 && (edge_cnt % 8) != 0; i++) step(1);
    for (int i = 0; i < 8; i++) begin
      ix = i / 2;
      n_vec++; if (tif.scan_digit !== exp_dig[ix]) begin n_bad++; $display("[TB] FAIL scan_digit c=%0d: got %h want %h", i, tif.scan_digit, exp_dig[ix]); end
      n_vec++; if (tif.scan_sel !== exp_sel[ix]) begin n_bad++; $display("[TB] FAIL scan_sel c=%0d: got %b want %b", i, tif.scan_sel, exp_sel[ix]); end
      n_vec++; if (tif.dp !== (ix != 2)) begin n_bad++; $display("[TB] FAIL scan_dp c=%0d: got %b want %b", i, tif.dp, (ix != 2)); end
      step(1);
    end
  endtask

  task automatic test_reset_async();
    do_reset();
    press();
    step(20);
    n_vec++; if (tif.digits !== 16'h0005) begin n_bad++; $display("[TB] FAIL async_pre: got %h want 0005", tif.digits); end
    rst = 1'b1;
    #2;
    n_vec++; if (tif.digits !== 16'h0000) begin n_bad++; $display("[TB] FAIL async_digits: got %h want 0000", tif.digits); end
    n_vec++; if (tif.running !== 1'b0) begin n_bad++; $display("[TB] FAIL async_running: got %b want 0", tif.running); end
    n_vec++; if (tif.scan_sel !== 4'b1110) begin n_bad++; $display("[TB] FAIL async_sel: got %b want 1110", tif.scan_sel); end
    n_vec++; if (tif.dp !== 1'b1) begin n_bad++; $display("[TB] FAIL async_dp: got %b want 1", tif.dp); end
    n_vec++; if (tif.scan_digit !== 4'h0) begin n_bad++; $display("[TB] FAIL async_scan_digit: got %h want 0", tif.scan_digit); end
    step(1);
    rst = 1'b0;
    step(5);
    n_vec++; if (tif.digits !== 16'h0000) begin n_bad++; $display("[TB] FAIL post_reset_idle: got %h want 0000", tif.digits); end
    n_vec++; if (tif.running !== 1'b0) begin n_bad++; $display("[TB] FAIL post_reset_run: got %b want 0", tif.running); end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    tif.start_stop = 1'b0;
    tif.clear = 1'b0;
    $display("[TB] starting bcd_timer bench");
    test_reset();
    test_run_stop();
    test_pause_resume();
    test_rollover();
    test_clear_tick();
    test_scan();
    test_reset_async();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
